// File: rtl/sobel_edge_3x3.sv
// Streaming 3x3 Sobel edge detector: two line buffers, |Gx|+|Gy| saturated onto R/G/B, 2-cycle latency.
// Optional binarisation of the edge value against thresh when SOBEL_THRESHOLD_EN is defined.
module sobel_edge_3x3 #(
   parameter int unsigned IMAGE_W = 640,
   parameter int unsigned IMAGE_H = 480,
   parameter int unsigned PIX_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic             in_sop,
   input  logic             in_eop,
   input  logic [PIX_W-1:0] grey,
   input  logic [PIX_W-1:0] thresh,
   output logic             out_valid,
   output logic             out_sop,
   output logic             out_eop,
   output logic [PIX_W-1:0] red_out,
   output logic [PIX_W-1:0] green_out,
   output logic [PIX_W-1:0] blue_out
);

   localparam int unsigned COL_W = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
   localparam int unsigned ROW_W = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1;
   localparam int unsigned GRAD_W = PIX_W + 3;
   localparam logic [GRAD_W-1:0] EDGE_MAX = GRAD_W'({PIX_W{1'b1}});

   logic [COL_W-1:0]  col, cur_col;
   logic [ROW_W-1:0]  row, cur_row;
   logic [PIX_W-1:0]  linebuf0 [IMAGE_W];
   logic [PIX_W-1:0]  linebuf1 [IMAGE_W];
   logic [PIX_W-1:0]  win      [3][3];
   logic [PIX_W-1:0]  nxt      [3][3];
   logic signed [GRAD_W-1:0] sx [3][3];
   logic signed [GRAD_W-1:0] gx_c, gy_c;

   logic                     s1_valid, s1_sop, s1_eop, s1_mask;
   logic signed [GRAD_W-1:0] s1_gx, s1_gy;

   logic [GRAD_W-1:0] abs_gx, abs_gy, mag;
   logic [PIX_W-1:0]  edge_c, pix_c, pix_q;

   // Position of the pixel on the input this cycle; sop restarts the frame at (0,0)
   always_comb begin
      cur_col = in_sop ? '0 : col;
      cur_row = in_sop ? '0 : row;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (cur_col == COL_W'(IMAGE_W - 1)) begin
            col <= '0;
            row <= (cur_row == ROW_W'(IMAGE_H - 1)) ? '0 : cur_row + 1'b1;
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end
   end

   // Window after this beat's shift: right column is {two lines up, one line up, new pixel}
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nxt[r][0] = win[r][1];
         nxt[r][1] = win[r][2];
         nxt[r][2] = win[r][2];
      end
      nxt[0][2] = linebuf1[cur_col];
      nxt[1][2] = linebuf0[cur_col];
      nxt[2][2] = grey;
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         linebuf1[cur_col] <= linebuf0[cur_col];
         linebuf0[cur_col] <= grey;
         win               <= nxt;
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            sx[r][c] = signed'(GRAD_W'(nxt[r][c]));
         end
      end
      gx_c = (sx[0][2] + sx[1][2] + sx[1][2] + sx[2][2])
           - (sx[0][0] + sx[1][0] + sx[1][0] + sx[2][0]);
      gy_c = (sx[2][0] + sx[2][1] + sx[2][1] + sx[2][2])
           - (sx[0][0] + sx[0][1] + sx[0][1] + sx[0][2]);
   end

   // Stage 1: gradients, border mask and framing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_sop   <= 1'b0;
         s1_eop   <= 1'b0;
         s1_mask  <= 1'b0;
         s1_gx    <= '0;
         s1_gy    <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sop  <= in_sop;
            s1_eop  <= in_eop;
            s1_mask <= (cur_col < COL_W'(2)) || (cur_row < ROW_W'(2));
            s1_gx   <= gx_c;
            s1_gy   <= gy_c;
         end
      end
   end

   always_comb begin
      abs_gx = s1_gx[GRAD_W-1] ? GRAD_W'(-s1_gx) : GRAD_W'(s1_gx);
      abs_gy = s1_gy[GRAD_W-1] ? GRAD_W'(-s1_gy) : GRAD_W'(s1_gy);
      mag    = abs_gx + abs_gy;
      edge_c = (mag > EDGE_MAX) ? '1 : mag[PIX_W-1:0];
      if (s1_mask) begin
         edge_c = '0;
      end
`ifdef SOBEL_THRESHOLD_EN
      pix_c = (edge_c > thresh) ? '1 : '0;
`else
      pix_c = edge_c;
`endif
   end

`ifndef SOBEL_THRESHOLD_EN
   logic unused_thresh;
   assign unused_thresh = ^thresh;
`endif

   // Stage 2: output beat; RGB holds across bubbles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         pix_q     <= '0;
      end else begin
         out_valid <= s1_valid;
         out_sop   <= s1_valid & s1_sop;
         out_eop   <= s1_valid & s1_eop;
         if (s1_valid) begin
            pix_q <= pix_c;
         end
      end
   end

   assign red_out   = pix_q;
   assign green_out = pix_q;
   assign blue_out  = pix_q;

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Scoreboard bench for sobel_edge_3x3 on a small 8x6 frame; reference model works on a frame image array.
module tb_sobel_edge_3x3;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int PW = 8;
   localparam int THRESH = 79;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sop = 1'b0;
   logic          in_eop = 1'b0;
   logic [PW-1:0] grey = '0;
   logic [PW-1:0] thresh = PW'(THRESH);
   logic          out_valid, out_sop, out_eop;
   logic [PW-1:0] red_out, green_out, blue_out;

   sobel_edge_3x3 #(.IMAGE_W(W), .IMAGE_H(H), .PIX_W(PW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .grey(grey), .thresh(thresh),
      .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          rgb;
      bit          sop;
      bit          eop;
      int unsigned at;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   img[H][W];
   int   mr = 0;
   int   mc = 0;
   int   last_rgb = 0;

   // Sobel magnitude of the 3x3 neighbourhood ending at (r,c), saturated, with border zeroing
   function automatic int model_edge(int r, int c);
      int p[3][3];
      int gx, gy, mag, e;
      if (r < 2 || c < 2) return 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = img[r-2+i][c-2+j];
      gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      e = (mag > 255) ? 255 : mag;
`ifdef SOBEL_THRESHOLD_EN
      e = (e > THRESH) ? 255 : 0;
`endif
      return e;
   endfunction

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         grey = PW'($urandom_range(0, 255));
      end
   endtask

   task automatic beat(bit sop, bit eop, int g);
      exp_t e;
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      grey     = PW'(g);
      if (sop) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = g;
      e.rgb = model_edge(mr, mc);
      e.sop = sop;
      e.eop = eop;
      e.at  = cyc + 2;
      q.push_back(e);
      if (mc == W - 1) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      grey     = PW'($urandom_range(0, 255));
   endtask

   // kind: 0 flat, 1 vertical step, 2 column ramp, 3 random; bub: 0 none, 1 alternate, 2 random gaps
   task automatic frame(int kind, int bub, int nbeats);
      int g, c;
      for (int k = 0; k < nbeats; k++) begin
         c = k % W;
         case (kind)
            0:       g = 100;
            1:       g = (c < 4) ? 0 : 255;
            2:       g = c * 10;
            default: g = $urandom_range(0, 255);
         endcase
         beat(k == 0, k == nbeats - 1, g);
         if (bub == 1) idle(1);
         else if (bub == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
   endtask

   task automatic do_reset(int n);
      reset_n = 1'b0;
      q.delete();
      mr = 0;
      mc = 0;
      in_valid = 1'b1;
      idle(n);
      in_valid = 1'b0;
      reset_n  = 1'b1;
   endtask

   // Monitor: compares every cycle away from the active edge
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         n_vec++;
         last_rgb = 0;
         if (out_valid || out_sop || out_eop || red_out != 0 || green_out != 0 || blue_out != 0) begin
            n_bad++;
            $display("FAIL reset: valid=%0b sop=%0b eop=%0b rgb=%0d/%0d/%0d, required all 0",
                     out_valid, out_sop, out_eop, red_out, green_out, blue_out);
         end
      end else if (out_valid) begin
         n_vec++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: out_valid=1 at cycle %0d, required no beat", cyc);
         end else begin
            e = q.pop_front();
            if (int'(red_out) != e.rgb || int'(green_out) != e.rgb || int'(blue_out) != e.rgb ||
                out_sop != e.sop || out_eop != e.eop || cyc != e.at) begin
               n_bad++;
               $display("FAIL beat: rgb=%0d/%0d/%0d sop=%0b eop=%0b cycle=%0d, required rgb=%0d sop=%0b eop=%0b cycle=%0d",
                        red_out, green_out, blue_out, out_sop, out_eop, cyc, e.rgb, e.sop, e.eop, e.at);
            end
            last_rgb = e.rgb;
         end
      end else begin
         n_vec++;
         if (out_sop || out_eop || int'(red_out) != last_rgb || int'(green_out) != last_rgb ||
             int'(blue_out) != last_rgb) begin
            n_bad++;
            $display("FAIL idle: sop=%0b eop=%0b rgb=%0d/%0d/%0d, required sop=0 eop=0 rgb=%0d",
                     out_sop, out_eop, red_out, green_out, blue_out, last_rgb);
         end
      end
   end

   initial begin
      #2;
      do_reset(4);
      frame(0, 0, W*H);
      idle(3);
      frame(1, 0, W*H);
      frame(2, 0, W*H);
      idle(2);
      frame(2, 1, W*H);
      for (int i = 0; i < 3; i++) frame(3, 2, W*H);
      frame(3, 0, 11);
      frame(2, 2, W*H);
      beat(1'b1, 1'b1, 77);
      idle(2);
      frame(3, 0, 2*W*H);
      frame(3, 0, 20);
      do_reset(3);
      frame(3, 2, W*H);
      frame(3, 0, 30);
      do_reset(1);
      idle(2);
      frame(1, 1, W*H);
      for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
      idle(2);
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d beats outstanding, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
